debounce_mc: RTL

Parametrised multi-channel successor to the single-button synchroniser/debouncer. Each of CH asynchronous inputs is synchronised, optionally inverted and debounced against a shared prescaled time base. Each channel outputs a clean level, single-cycle press and release strobes, a long-press level and auto-repeat strobes. Sits between the front-panel buttons/switches and the I2C master control logic.

---
 rtl/debounce_mc.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/debounce_mc.sv
// debounce_mc: CH-channel synchroniser/debouncer with long-press detection and auto-repeat.
// All channels share one prescaled tick; each channel owns a debounce counter and a hold FSM.
module debounce_mc #(
   parameter int CH         = 4,
   parameter int INVERT     = 1,
   parameter int PRE_DIV    = 256,
   parameter int CW         = 16,
   parameter int DEB_TICKS  = 16,
   parameter int HOLD_TICKS = 2000,
   parameter int REP_TICKS  = 250
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CH-1:0] but,
   output logic [CH-1:0] signal,
   output logic [CH-1:0] sigup,
   output logic [CH-1:0] sigdn,
   output logic [CH-1:0] long_st,
   output logic [CH-1:0] rep,
   output logic          tick
);

   localparam int PW = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST  = PW'(PRE_DIV - 1);
   localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_TICKS - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);
   localparam logic [CW-1:0] REP_LAST  = (REP_TICKS > 0) ? CW'(REP_TICKS - 1) : '0;
   localparam longint CNT_MAX = (longint'(1) << CW) - 1;
   localparam bit CFG_OK = (CH >= 1) && (PRE_DIV >= 1) && (CW >= 1) && (CW <= 31) &&
                           (DEB_TICKS >= 1) && (DEB_TICKS <= CNT_MAX) &&
                           (HOLD_TICKS >= 1) && (HOLD_TICKS <= CNT_MAX) &&
                           (REP_TICKS >= 0) && (REP_TICKS <= CNT_MAX);

   typedef enum logic [1:0] {
      H_IDLE = 2'd0,
      H_HOLD = 2'd1,
      H_LONG = 2'd2
   } hold_state_e;

   logic [PW-1:0] pre_cnt_q, pre_cnt_d;
   logic [CH-1:0] s0_q, s0_d, s1_q, s1_d;
   logic [CH-1:0] signal_q, signal_d, sigup_q, sigup_d, sigdn_q, sigdn_d;
   logic [CH-1:0] long_st_q, long_st_d, rep_q, rep_d;
   logic [CW-1:0] deb_cnt_q  [CH];
   logic [CW-1:0] deb_cnt_d  [CH];
   logic [CW-1:0] hold_cnt_q [CH];
   logic [CW-1:0] hold_cnt_d [CH];
   hold_state_e   hold_st_q  [CH];
   hold_state_e   hold_st_d  [CH];

   assign tick = (pre_cnt_q == PRE_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt_q <= '0;
         s0_q      <= '0;
         s1_q      <= '0;
         signal_q  <= '0;
         sigup_q   <= '0;
         sigdn_q   <= '0;
         long_st_q <= '0;
         rep_q     <= '0;
         for (int i = 0; i < CH; i++) begin
            deb_cnt_q[i]  <= '0;
            hold_cnt_q[i] <= '0;
            hold_st_q[i]  <= H_IDLE;
         end
      end else begin
         pre_cnt_q <= pre_cnt_d;
         s0_q      <= s0_d;
         s1_q      <= s1_d;
         signal_q  <= signal_d;
         sigup_q   <= sigup_d;
         sigdn_q   <= sigdn_d;
         long_st_q <= long_st_d;
         rep_q     <= rep_d;
         for (int i = 0; i < CH; i++) begin
            deb_cnt_q[i]  <= deb_cnt_d[i];
            hold_cnt_q[i] <= hold_cnt_d[i];
            hold_st_q[i]  <= hold_st_d[i];
         end
      end
   end

   // Prescaler, synchroniser and debounce; a disagreement must survive DEB_TICKS ticks.
   always_comb begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
      s0_d      = (INVERT != 0) ? ~but : but;
      s1_d      = s0_q;
      signal_d  = signal_q;
      sigup_d   = '0;
      sigdn_d   = '0;
      for (int i = 0; i < CH; i++) begin
         deb_cnt_d[i] = deb_cnt_q[i];
         if (signal_q[i] == s1_q[i]) begin
            deb_cnt_d[i] = '0;
         end else if (tick) begin
            if (deb_cnt_q[i] == DEB_LAST) begin
               signal_d[i]  = s1_q[i];
               deb_cnt_d[i] = '0;
               sigup_d[i]   = s1_q[i];
               sigdn_d[i]   = ~s1_q[i];
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Hold FSM reacts to the same-edge press/release so long_st drops together with signal.
   always_comb begin
      long_st_d = long_st_q;
      rep_d     = '0;
      for (int i = 0; i < CH; i++) begin
         hold_st_d[i]  = hold_st_q[i];
         hold_cnt_d[i] = hold_cnt_q[i];
         case (hold_st_q[i])
            H_IDLE: begin
               if (sigup_d[i]) begin
                  hold_st_d[i]  = H_HOLD;
                  hold_cnt_d[i] = '0;
               end
            end
            H_HOLD: begin
               if (tick) begin
                  if (hold_cnt_q[i] == HOLD_LAST) begin
                     hold_st_d[i]  = H_LONG;
                     hold_cnt_d[i] = '0;
                     long_st_d[i]  = 1'b1;
                     rep_d[i]      = 1'b1;
                  end else begin
                     hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
                  end
               end
            end
            H_LONG: begin
               if (tick && (REP_TICKS > 0)) begin
                  if (hold_cnt_q[i] == REP_LAST) begin
                     hold_cnt_d[i] = '0;
                     rep_d[i]      = 1'b1;
                  end else begin
                     hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
                  end
               end
            end
            default: hold_st_d[i] = H_IDLE;
         endcase
         if (sigdn_d[i]) begin
            hold_st_d[i]  = H_IDLE;
            hold_cnt_d[i] = '0;
            long_st_d[i]  = 1'b0;
            rep_d[i]      = 1'b0;
         end
      end
   end

   assign signal  = signal_q;
   assign sigup   = sigup_q;
   assign sigdn   = sigdn_q;
   assign long_st = long_st_q;
   assign rep     = rep_q;

   always_ff @(posedge clk) begin : cfg_check
      assert (CFG_OK) else $error("debounce_mc: parameter out of range");
   end

endmodule
